// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the fetch -> pre-decode instruction queue.
// Holds field widths, the packed entry layout with its bit offsets, and
// pack/unpack helpers so fetch and pre-decode agree on the entry format.
package inst_fetch_queue_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int BP_GHR_BITS     = 8;
  localparam int IF_BATCH_SIZE   = 2;
  localparam int FQ_DEPTH        = 8;

  localparam int FQ_ENTRY_W    = INST_WIDTH + 1 + INST_ADDR_WIDTH + BP_GHR_BITS;
  localparam int FQ_INST_LSB   = 0;
  localparam int FQ_TAKEN_BIT  = INST_WIDTH;
  localparam int FQ_TARGET_LSB = INST_WIDTH + 1;
  localparam int FQ_HIST_LSB   = FQ_TARGET_LSB + INST_ADDR_WIDTH;

  // Field order matches the offsets above: inst lives in the LSBs.
  typedef struct packed {
    logic [BP_GHR_BITS-1:0]     pred_hist;
    logic [INST_ADDR_WIDTH-1:0] pred_target;
    logic                       pred_taken;
    logic [INST_WIDTH-1:0]      inst;
  } fq_entry_t;

  typedef logic [FQ_ENTRY_W-1:0] fq_raw_t;

  function automatic fq_raw_t fq_pack(input logic [INST_WIDTH-1:0]      inst,
                                      input logic                       taken,
                                      input logic [INST_ADDR_WIDTH-1:0] target,
                                      input logic [BP_GHR_BITS-1:0]     hist);
    return {hist, target, taken, inst};
  endfunction

  function automatic logic [INST_WIDTH-1:0] fq_get_inst(input fq_raw_t e);
    return e[FQ_INST_LSB +: INST_WIDTH];
  endfunction

  function automatic logic fq_get_taken(input fq_raw_t e);
    return e[FQ_TAKEN_BIT];
  endfunction

  function automatic logic [INST_ADDR_WIDTH-1:0] fq_get_target(input fq_raw_t e);
    return e[FQ_TARGET_LSB +: INST_ADDR_WIDTH];
  endfunction

  function automatic logic [BP_GHR_BITS-1:0] fq_get_hist(input fq_raw_t e);
    return e[FQ_HIST_LSB +: BP_GHR_BITS];
  endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Entry storage for the instruction fetch queue: DEPTH x ENTRY_W registers.
// Ports: clk; two write ports (i_wrN_en/addr/dat); two async read ports
// (i_rdN_addr -> o_rdN_dat). Contents are not reset.
module inst_fetch_queue_ram #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int ENTRY_W = 73
) (
  input  logic               clk,
  input  logic               i_wr0_en,
  input  logic [PTR_W-1:0]   i_wr0_addr,
  input  logic [ENTRY_W-1:0] i_wr0_dat,
  input  logic               i_wr1_en,
  input  logic [PTR_W-1:0]   i_wr1_addr,
  input  logic [ENTRY_W-1:0] i_wr1_dat,
  input  logic [PTR_W-1:0]   i_rd0_addr,
  output logic [ENTRY_W-1:0] o_rd0_dat,
  input  logic [PTR_W-1:0]   i_rd1_addr,
  output logic [ENTRY_W-1:0] o_rd1_dat
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // The two write addresses are always consecutive slots, so they never collide.
  always_ff @(posedge clk) begin
    if (i_wr0_en) r_mem[i_wr0_addr] <= i_wr0_dat;
    if (i_wr1_en) r_mem[i_wr1_addr] <= i_wr1_dat;
  end

  assign o_rd0_dat = r_mem[i_rd0_addr];
  assign o_rd1_dat = r_mem[i_rd1_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// 2-wide in / 2-wide out circular instruction queue between fetch and pre-decode.
// Ports: clk, rst_n, flush; in_entry_0/1 + in_inst_valid -> in_ready (whole batch or none);
// out_entry_0/1 + out_inst_valid <- out_ready; count = occupancy.
// Optional macro FETCH_QUEUE_PERF_EN adds perf_stall_cycles and perf_flush_count outputs.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = FQ_DEPTH,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int ENTRY_W = FQ_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       in_entry_0,
  input  logic [ENTRY_W-1:0]       in_entry_1,
  input  logic [IF_BATCH_SIZE-1:0] in_inst_valid,
  output logic                     in_ready,
  output logic [ENTRY_W-1:0]       out_entry_0,
  output logic [ENTRY_W-1:0]       out_entry_1,
  output logic [IF_BATCH_SIZE-1:0] out_inst_valid,
  input  logic                     out_ready,
  output logic [PTR_W:0]           count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flush_count
`endif
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_enq;
  logic [CNT_W-1:0]   w_enq_n;
  logic [CNT_W-1:0]   w_deq_n;
  logic               w_both;
  logic [ENTRY_W-1:0] w_wr0_dat;
  logic [ENTRY_W-1:0] w_rd0_dat;
  logic [ENTRY_W-1:0] w_rd1_dat;

  // Room for a full 2-wide batch, judged on registered occupancy only; a
  // same-cycle dequeue is deliberately not credited.
  assign in_ready = (r_count <= CNT_W'(DEPTH - 2));

  always_comb begin
    out_inst_valid = 2'b00;
    if (r_count == CNT_W'(1))      out_inst_valid = 2'b01;
    else if (r_count >= CNT_W'(2)) out_inst_valid = 2'b11;
  end

  assign w_both  = &in_inst_valid;
  assign w_enq   = in_ready & (|in_inst_valid) & ~flush;
  assign w_enq_n = !w_enq ? '0 : (w_both ? CNT_W'(2) : CNT_W'(1));
  assign w_deq_n = (out_ready & ~flush)
                 ? CNT_W'(out_inst_valid[0]) + CNT_W'(out_inst_valid[1]) : '0;

  // Compaction: a lone slot-1 instruction still lands at the tail.
  assign w_wr0_dat = in_inst_valid[0] ? in_entry_0 : in_entry_1;

  inst_fetch_queue_ram #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk        (clk),
    .i_wr0_en   (w_enq),
    .i_wr0_addr (r_tail),
    .i_wr0_dat  (w_wr0_dat),
    .i_wr1_en   (w_enq & w_both),
    .i_wr1_addr (r_tail + PTR_W'(1)),
    .i_wr1_dat  (in_entry_1),
    .i_rd0_addr (r_head),
    .o_rd0_dat  (w_rd0_dat),
    .i_rd1_addr (r_head + PTR_W'(1)),
    .o_rd1_dat  (w_rd1_dat)
  );

  assign out_entry_0 = out_inst_valid[0] ? w_rd0_dat : '0;
  assign out_entry_1 = out_inst_valid[1] ? w_rd1_dat : '0;
  assign count       = r_count;

  // Pointers wrap naturally at PTR_W bits; full vs empty comes from r_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Saturating counters; only rst_n clears them, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((|in_inst_valid) && !in_ready && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (flush && !(&r_flush_count))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign perf_stall_cycles = r_stall_cycles;
  assign perf_flush_count  = r_flush_count;
`endif

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
                                r_count <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   w_deq_n <= r_count);
  a_valid_shape: assert property (@(posedge clk) disable iff (!rst_n)
                                  out_inst_valid != 2'b10);
  a_enq_ready: assert property (@(posedge clk) disable iff (!rst_n)
                                w_enq |-> in_ready);

endmodule
